mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle main control unit. Sequences the shared datapath (one ALU, one memory port, PC, IR, MDR, ALUOut, register file)
//  through fetch/decode/execute/memory/writeback. Drives the 4-bit ALUOp into the ALU control decoder.
//  Stalls on a ready/request memory handshake, enforces a memory watchdog and counts retired instructions.
// PARAMETERS
//  TIMEOUT_CYC  255  max wait cycles for mem_ready in a memory state; exceeded -> TRAP with bus_err=1
//  RETIRE_W     32   width of the instr_retired counter
// PORTS
//  clk            in   1         single clock, all state on rising edge
//  rst_n          in   1         asynchronous, active-low reset
//  opcode         in   6         IR[31:26]; stable from DECODE until the next FETCH
//  funct          in   6         IR[5:0]
//  zero           in   1         ALU zero flag
//  mem_ready      in   1         memory completes the current request this cycle
//  mem_req        out  1         memory request, held until mem_ready
//  mem_we         out  1         1 = write request (SW)
//  iord           out  1         memory address: 0 = PC, 1 = ALUOut
//  ir_write       out  1         load IR from memory data
//  pc_write       out  1         load PC (already qualified for branches)
//  pc_src         out  2         00 ALU result, 01 ALUOut, 10 jump target, 11 rs
//  alu_src_a      out  1         0 = PC, 1 = rs
//  alu_src_b      out  2         00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//  ALUOp          out  4         0 RTYPE(funct), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 LUI
//  reg_write      out  1         register file write enable
//  reg_dst        out  2         00 rt, 01 rd, 10 $31
//  mem_to_reg     out  2         00 ALUOut, 01 MDR, 10 PC
//  halted         out  1         core stopped (HALT or TRAP)
//  illegal        out  1         undefined opcode or R-type funct trapped
//  bus_err        out  1         memory watchdog expired
//  instr_retired  out  RETIRE_W  count of completed instructions, wraps modulo 2^RETIRE_W
//  state_dbg      out  4         current state encoding
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. All outputs 0, watchdog counter 0, instr_retired 0. mem_req drops in the same cycle.
//  IDLE: next clock -> FETCH. No retire count.
//  FETCH: mem_req=1, iord=0. Wait while !mem_ready.
//    On mem_ready (Mealy): ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, ALUOp=ADD -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, ALUOp=ADD (branch target into ALUOut). Dispatch:
//    op 00, funct 0F -> JR; op 00, funct 01..0E -> EXEC_R; op 00, other funct -> TRAP.
//    08/0C/0D/0E/0A/0B/0F (ADDI/ANDI/ORI/XORI/SLTI/SLTIU/LUI) -> EXEC_I.
//    23 LW / 2B SW -> MEM_ADDR. 04 BEQ / 05 BNE -> BRANCH. 02 J / 03 JAL -> JUMP. 3F -> HALT. Any other opcode -> TRAP.
//  EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=RTYPE -> WB_R.
//  WB_R: reg_write, reg_dst=01, mem_to_reg=00 -> FETCH.
//  EXEC_I: alu_src_a=1, alu_src_b=10, ALUOp: ADDI 1, ANDI 3, ORI 4, XORI 5, SLTI 6, SLTIU 7, LUI 8 -> WB_I.
//  WB_I: reg_write, reg_dst=00, mem_to_reg=00 -> FETCH.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=ADD -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: mem_req, iord=1; wait for mem_ready -> MEM_WB.
//  MEM_WB: reg_write, reg_dst=00, mem_to_reg=01 -> FETCH.
//  MEM_WR: mem_req, mem_we, iord=1; wait for mem_ready -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=SUB, pc_src=01. pc_write = zero (BEQ) or !zero (BNE) -> FETCH.
//  JUMP: pc_write, pc_src=10. JAL also asserts reg_write, reg_dst=10, mem_to_reg=10 (PC already +4) -> FETCH.
//  JR: pc_write, pc_src=11 -> FETCH.
//  HALT: halted=1, terminal until reset. TRAP: halted=1, plus illegal or bus_err (sticky), terminal until reset.
//  Latency (zero-wait memory): R/I 4, LW 5, SW 4, BEQ/BNE/J/JAL/JR 3 cycles. Each extra wait cycle adds 1.
//  Any control output not listed for a state is 0.
//  Watchdog: counts cycles spent in FETCH/MEM_RD/MEM_WR with mem_req=1 and !mem_ready; clears on state change.
//    Reaching TIMEOUT_CYC -> TRAP, bus_err=1, mem_req drops. mem_ready in the same cycle as expiry wins: normal advance.
//  instr_retired increments on every transition into FETCH from a completion state. Never from IDLE; not on HALT/TRAP.
//  All unlisted encodings of the 4-bit state register -> TRAP with illegal=1 (recovery from an upset).
// STRUCTURE
//  Shared include ctrl_defs.vh: opcode/funct codes, ALUOp codes, state encodings, pc_src/alu_src_b/reg_dst/mem_to_reg select codes.
//  Sub-module ctrl_opdecode (combinational): opcode,funct -> instruction class + I-type ALUOp; used by DECODE/EXEC_I.
//  Top: state register, watchdog counter, retire counter, output decode.
// TESTING
//  Reset held, mem_ready=1 -> all outputs 0, state_dbg=IDLE. Release -> FETCH next cycle, mem_req=1.
//  ADD (op 00, funct 01), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R. ALUOp=0 in EXEC_R, reg_dst=01 in WB_R, instr_retired=1.
//  LW with mem_ready low 3 cycles in MEM_RD -> 8 cycles total. iord=1 throughout the wait, reg_write only in MEM_WB.
//  BEQ zero=1 -> pc_write=1, pc_src=01. BEQ zero=0 -> pc_write=0. BNE zero=0 -> pc_write=1.
//  Opcode 3E -> TRAP, illegal=1, halted=1. mem_ready never high, TIMEOUT_CYC=4 -> TRAP after 4 wait cycles, bus_err=1.
//  rst_n low mid-MEM_WR -> mem_req/mem_we drop immediately, counters 0, restart through IDLE.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared codes for the multicycle control unit: states, opcode/funct,
// ALUOp, datapath select values and decoded instruction classes.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_JR, C_I, C_MEM,
    C_BR, C_J, C_HALT, C_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h0F;

  localparam logic [3:0] ALU_RTYPE = 4'd0;
  localparam logic [3:0] ALU_ADD   = 4'd1;
  localparam logic [3:0] ALU_SUB   = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_LUI   = 4'd8;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_RS  = 2'b11;

  localparam logic [1:0] SB_RT  = 2'b00;
  localparam logic [1:0] SB_4   = 2'b01;
  localparam logic [1:0] SB_IMM = 2'b10;
  localparam logic [1:0] SB_BR  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle. master = control unit,
// slave = datapath side (instruction fields, flags, mem handshake).
interface mc_ctrl_fsm_if #(
  parameter int RETIRE_W = 32
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [3:0]          ALUOp;
  logic                reg_write;
  logic [1:0]          reg_dst;
  logic [1:0]          mem_to_reg;
  logic                halted;
  logic                illegal;
  logic                bus_err;
  logic [RETIRE_W-1:0] instr_retired;
  logic [3:0]          state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write,
    output pc_write, pc_src, alu_src_a,
    output alu_src_b, ALUOp, reg_write,
    output reg_dst, mem_to_reg, halted,
    output illegal, bus_err, instr_retired,
    output state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write,
    input  pc_write, pc_src, alu_src_a,
    input  alu_src_b, ALUOp, reg_write,
    input  reg_dst, mem_to_reg, halted,
    input  illegal, bus_err, instr_retired,
    input  state_dbg
  );
endinterface

// File: rtl/mc_ctrl_fsm_opdecode.sv
// Opcode/funct -> instruction class and I-type ALUOp.
// Ports: opcode_i, funct_i in; cls_o, alu_op_o out.
module mc_ctrl_fsm_opdecode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic [3:0] alu_op_o
);
  always_comb begin
    cls_o    = C_ILL;
    alu_op_o = ALU_ADD;
    unique case (opcode_i)
      OP_RTYPE: begin
        if (funct_i == FN_JR)
          cls_o = C_JR;
        else if (funct_i != 6'h00 && funct_i < FN_JR)
          cls_o = C_R;
      end
      OP_ADDI:  begin cls_o = C_I; alu_op_o = ALU_ADD;  end
      OP_ANDI:  begin cls_o = C_I; alu_op_o = ALU_AND;  end
      OP_ORI:   begin cls_o = C_I; alu_op_o = ALU_OR;   end
      OP_XORI:  begin cls_o = C_I; alu_op_o = ALU_XOR;  end
      OP_SLTI:  begin cls_o = C_I; alu_op_o = ALU_SLT;  end
      OP_SLTIU: begin cls_o = C_I; alu_op_o = ALU_SLTU; end
      OP_LUI:   begin cls_o = C_I; alu_op_o = ALU_LUI;  end
      OP_LW, OP_SW:   cls_o = C_MEM;
      OP_BEQ, OP_BNE: cls_o = C_BR;
      OP_J, OP_JAL:   cls_o = C_J;
      OP_HALT:        cls_o = C_HALT;
      default:        cls_o = C_ILL;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main control FSM with memory watchdog and retire counter.
// Ports: clk, rst_n (async low), bus (mc_ctrl_fsm_if.master).
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int RETIRE_W    = 32
) (
  input logic          clk,
  input logic          rst_n,
  mc_ctrl_fsm_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [RETIRE_W-1:0] ret_q, ret_d;
  logic                ill_q, ill_d;
  logic                berr_q, berr_d;
  iclass_e             cls;
  logic [3:0]          i_aluop;
  logic                wait_c, expire;

  mc_ctrl_fsm_opdecode u_dec (
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .cls_o    (cls),
    .alu_op_o (i_aluop)
  );

  // A wait cycle is any memory state stalled on mem_ready;
  // a ready in the expiry cycle is not a wait, so it advances.
  assign wait_c = (state_q == S_FETCH || state_q == S_MEM_RD ||
                   state_q == S_MEM_WR) && !bus.mem_ready;
  assign expire = wait_c && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign wd_d   = (wait_c && !expire) ? wd_q + WD_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      ret_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ill_d          = ill_q;
    berr_d         = berr_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SB_RT;
    bus.ALUOp      = ALU_RTYPE;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = RD_RT;
    bus.mem_to_reg = M2R_ALU;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_b = SB_4;
          bus.ALUOp     = ALU_ADD;
          state_d       = S_DECODE;
        end else if (expire) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = SB_BR;
        bus.ALUOp     = ALU_ADD;
        unique case (cls)
          C_R:    state_d = S_EXEC_R;
          C_JR:   state_d = S_JR;
          C_I:    state_d = S_EXEC_I;
          C_MEM:  state_d = S_MEM_ADDR;
          C_BR:   state_d = S_BRANCH;
          C_J:    state_d = S_JUMP;
          C_HALT: state_d = S_HALT;
          default: begin
            ill_d   = 1'b1;
            state_d = S_TRAP;
          end
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        state_d       = S_WB_R;
      end
      S_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = RD_RD;
        state_d       = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_IMM;
        bus.ALUOp     = i_aluop;
        state_d       = S_WB_I;
      end
      S_WB_I: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_IMM;
        bus.ALUOp     = ALU_ADD;
        state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expire) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = M2R_MDR;
        state_d        = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (expire) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOp     = ALU_SUB;
        bus.pc_src    = PC_OUT;
        bus.pc_write  = (bus.opcode == OP_BNE) ? !bus.zero
                                               : bus.zero;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_JMP;
        if (bus.opcode == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = RD_RA;
          bus.mem_to_reg = M2R_PC;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_RS;
        state_d      = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_TRAP: state_d = S_TRAP;
      default: begin
        ill_d   = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // Retire on every return to FETCH from a completing state.
  assign ret_d = (state_d == S_FETCH && state_q != S_FETCH &&
                  state_q != S_IDLE) ? ret_q + RETIRE_W'(1) : ret_q;

  assign bus.halted        = (state_q == S_HALT) ||
                             (state_q == S_TRAP);
  assign bus.illegal       = ill_q;
  assign bus.bus_err       = berr_q;
  assign bus.instr_retired = ret_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instruction flows, stalls,
// branch qualification, traps, watchdog and async reset.
module tb_mc_ctrl_fsm;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   t0;

  mc_ctrl_fsm_if #(.RETIRE_W(32)) bus ();

  mc_ctrl_fsm #(
    .TIMEOUT_CYC (4),
    .RETIRE_W    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {8'h0, bus.mem_req, bus.mem_we, bus.iord,
            bus.ir_write, bus.pc_write, bus.pc_src,
            bus.alu_src_a, bus.alu_src_b, bus.ALUOp,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.halted, bus.illegal, bus.bus_err};
  endfunction

  // Fetch with ready and land in the execute state after DECODE.
  task automatic fetch_decode(input logic [5:0] op,
                              input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_state", bus.state_dbg, 4'd1);
    step();
    chk("decode_state", bus.state_dbg, 4'd2);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    step();
    chk("rst_state", bus.state_dbg, 4'd0);
    chk("rst_outs", all_out(), 32'h0);
    chk("rst_retired", bus.instr_retired, 0);

    rst_n = 1'b1;
    step();
    chk("rel_fetch", bus.state_dbg, 4'd1);
    chk("rel_mreq", bus.mem_req, 1);

    // ADD
    bus.funct = 6'h01;
    #1;
    chk("f_irw", bus.ir_write, 1);
    chk("f_pcw", bus.pc_write, 1);
    chk("f_srcb", bus.alu_src_b, 2'b01);
    chk("f_aluop", bus.ALUOp, 4'd1);
    chk("f_iord", bus.iord, 0);
    step();
    chk("dec_state", bus.state_dbg, 4'd2);
    chk("dec_srcb", bus.alu_src_b, 2'b11);
    chk("dec_aluop", bus.ALUOp, 4'd1);
    step();
    chk("exr_state", bus.state_dbg, 4'd3);
    chk("exr_aluop", bus.ALUOp, 4'd0);
    chk("exr_srca", bus.alu_src_a, 1);
    step();
    chk("wbr_state", bus.state_dbg, 4'd4);
    chk("wbr_regw", bus.reg_write, 1);
    chk("wbr_dst", bus.reg_dst, 2'b01);
    step();
    chk("add_ret", bus.instr_retired, 1);

    // LW with 3 wait cycles in MEM_RD: 8 cycles total
    t0 = cyc;
    fetch_decode(6'h23, 6'h00);
    chk("lw_maddr", bus.state_dbg, 4'd7);
    chk("lw_srcb", bus.alu_src_b, 2'b10);
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_st", bus.state_dbg, 4'd8);
      chk("lw_wait_iord", bus.iord, 1);
      chk("lw_wait_regw", bus.reg_write, 0);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_rd_st", bus.state_dbg, 4'd8);
    step();
    chk("lw_wb_st", bus.state_dbg, 4'd9);
    chk("lw_wb_regw", bus.reg_write, 1);
    chk("lw_wb_m2r", bus.mem_to_reg, 2'b01);
    step();
    chk("lw_cycles", cyc - t0, 8);
    chk("lw_ret", bus.instr_retired, 2);

    // ORI
    fetch_decode(6'h0D, 6'h00);
    chk("ori_st", bus.state_dbg, 4'd5);
    chk("ori_aluop", bus.ALUOp, 4'd4);
    chk("ori_srcb", bus.alu_src_b, 2'b10);
    step();
    chk("ori_wb_dst", bus.reg_dst, 2'b00);
    chk("ori_wb_regw", bus.reg_write, 1);
    step();
    chk("ori_ret", bus.instr_retired, 3);

    // BEQ taken
    bus.zero = 1'b1;
    fetch_decode(6'h04, 6'h00);
    chk("beq1_st", bus.state_dbg, 4'd11);
    chk("beq1_pcw", bus.pc_write, 1);
    chk("beq1_src", bus.pc_src, 2'b01);
    chk("beq1_alu", bus.ALUOp, 4'd2);
    step();
    chk("beq1_ret", bus.instr_retired, 4);

    // BEQ not taken
    bus.zero = 1'b0;
    fetch_decode(6'h04, 6'h00);
    chk("beq0_pcw", bus.pc_write, 0);
    step();

    // BNE taken on zero=0
    fetch_decode(6'h05, 6'h00);
    chk("bne0_pcw", bus.pc_write, 1);
    step();
    chk("bne_ret", bus.instr_retired, 6);

    // JAL
    fetch_decode(6'h03, 6'h00);
    chk("jal_st", bus.state_dbg, 4'd12);
    chk("jal_src", bus.pc_src, 2'b10);
    chk("jal_dst", bus.reg_dst, 2'b10);
    chk("jal_m2r", bus.mem_to_reg, 2'b10);
    chk("jal_regw", bus.reg_write, 1);
    step();

    // JR
    fetch_decode(6'h00, 6'h0F);
    chk("jr_st", bus.state_dbg, 4'd13);
    chk("jr_src", bus.pc_src, 2'b11);
    chk("jr_pcw", bus.pc_write, 1);
    step();
    chk("jr_ret", bus.instr_retired, 8);

    // SW, async reset while stalled in MEM_WR
    fetch_decode(6'h2B, 6'h00);
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_st", bus.state_dbg, 4'd10);
    chk("sw_we", bus.mem_we, 1);
    chk("sw_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("swrst_req", bus.mem_req, 0);
    chk("swrst_we", bus.mem_we, 0);
    chk("swrst_st", bus.state_dbg, 4'd0);
    chk("swrst_ret", bus.instr_retired, 0);
    rst_n = 1'b1;

    // Watchdog: no ready in FETCH
    step();
    chk("wd_fetch", bus.state_dbg, 4'd1);
    step();
    step();
    step();
    chk("wd_pre", bus.state_dbg, 4'd1);
    chk("wd_pre_berr", bus.bus_err, 0);
    step();
    chk("wd_trap", bus.state_dbg, 4'd15);
    chk("wd_berr", bus.bus_err, 1);
    chk("wd_halt", bus.halted, 1);
    chk("wd_req", bus.mem_req, 0);
    chk("wd_ill", bus.illegal, 0);

    // Illegal opcode 3E
    rst_n = 1'b0;
    #1;
    chk("rst2_berr", bus.bus_err, 0);
    rst_n = 1'b1;
    step();
    fetch_decode(6'h3E, 6'h00);
    chk("ill_st", bus.state_dbg, 4'd15);
    chk("ill_ill", bus.illegal, 1);
    chk("ill_halt", bus.halted, 1);
    chk("ill_berr", bus.bus_err, 0);
    step();
    chk("ill_stay", bus.state_dbg, 4'd15);
    chk("ill_ret", bus.instr_retired, 0);

    // Undefined R-type funct traps too
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    fetch_decode(6'h00, 6'h20);
    chk("rfn_ill", bus.illegal, 1);

    // HALT
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    fetch_decode(6'h3F, 6'h00);
    chk("halt_st", bus.state_dbg, 4'd14);
    chk("halt_h", bus.halted, 1);
    chk("halt_ill", bus.illegal, 0);
    step();
    chk("halt_stay", bus.state_dbg, 4'd14);
    chk("halt_req", bus.mem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
